// File: rtl/ddr3_sniffer_reader.sv
// Read-only DDR3 sniffer-port initiator: issues a run of credit-limited READ bursts
// and streams the captured beats out through a small FIFO on a valid/ready port.
//
// state | meaning
// IDLE  | waiting for start; stray read beats are dropped and flagged
// ISSUE | presenting READ commands while FIFO credit allows
// DRAIN | all commands accepted; waiting for beats to arrive and be consumed
module ddr3_sniffer_reader #(
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [31:0] ADDR_STEP       = 32'd8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [31:0]  base_addr,
    input  logic [15:0]  num_bursts,
    output logic         busy,
    output logic         done,
    output logic         err_unexpected,
    output logic [287:0] out_data,
    output logic         out_valid,
    output logic         out_last,
    input  logic         out_ready,
    output logic [31:0]  ddr_addr,
    output logic         ddr_en,
    output logic [2:0]   ddr_cmd,
    output logic         ddr_wdf_wren,
    output logic [287:0] ddr_wdf_data,
    output logic [35:0]  ddr_wdf_mask,
    output logic         ddr_wdf_end,
    input  logic [287:0] ddr_rd_data,
    input  logic         ddr_rd_data_valid,
    input  logic         ddr_rd_data_end,
    input  logic         ddr_rdy,
    input  logic         ddr_wdf_rdy
);

    localparam int DEPTH = 2 * MAX_OUTSTANDING;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    addr_q, addr_d;
    logic [15:0]    num_q, num_d;
    logic [15:0]    issued_q, issued_d;
    logic [CW-1:0]  pend_q, pend_d;
    logic [CW-1:0]  resv_q, resv_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [16:0]    beats_out_q, beats_out_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic           err_q, err_d;
    logic           done_q, done_d;
    logic [287:0]   mem_q [DEPTH];

    logic           start_acc;
    logic           cmd_acc;
    logic           beat_wr;
    logic           out_hs;
    logic [16:0]    total_beats;

    wire unused_inputs = ^{ddr_rd_data_end, ddr_wdf_rdy};

    assign start_acc   = start && (state_q == S_IDLE);
    // Credit check uses reserved, which only rises on accept, so ddr_en cannot drop while stalled.
    assign ddr_en      = (state_q == S_ISSUE) && (resv_q <= CREDIT_MAX);
    assign cmd_acc     = ddr_en && ddr_rdy;
    assign beat_wr     = ddr_rd_data_valid && (pend_q != '0);
    assign out_valid   = (cnt_q != '0);
    assign out_hs      = out_valid && out_ready;
    assign out_data    = out_valid ? mem_q[rd_ptr_q] : '0;
    assign total_beats = {num_q, 1'b0};
    assign out_last    = out_valid && (beats_out_q == total_beats - 17'd1);

    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign err_unexpected = err_q;
    assign ddr_addr       = addr_q;
    assign ddr_cmd        = 3'b001;
    assign ddr_wdf_wren   = 1'b0;
    assign ddr_wdf_data   = '0;
    assign ddr_wdf_mask   = '1;
    assign ddr_wdf_end    = 1'b0;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        num_d       = num_q;
        issued_d    = issued_q;
        done_d      = 1'b0;
        err_d       = err_q;
        pend_d      = pend_q + (cmd_acc ? CW'(2) : CW'(0)) - CW'(beat_wr);
        resv_d      = resv_q + (cmd_acc ? CW'(2) : CW'(0)) - CW'(out_hs);
        cnt_d       = cnt_q + CW'(beat_wr) - CW'(out_hs);
        beats_out_d = beats_out_q + 17'(out_hs);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;

        if (beat_wr) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (out_hs) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        if (cmd_acc) begin
            addr_d   = addr_q + ADDR_STEP;
            issued_d = issued_q + 16'd1;
        end

        if (start_acc) begin
            err_d = 1'b0;
        end
        if (ddr_rd_data_valid && (pend_q == '0)) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_acc) begin
                    addr_d      = base_addr;
                    num_d       = num_bursts;
                    issued_d    = '0;
                    beats_out_d = '0;
                    if (num_bursts == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (cmd_acc && (issued_q == num_q - 16'd1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Looking at next-cycle counts puts done right after the final handshake.
                if ((pend_d == '0) && (cnt_d == '0)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            num_q       <= '0;
            issued_q    <= '0;
            pend_q      <= '0;
            resv_q      <= '0;
            cnt_q       <= '0;
            beats_out_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            num_q       <= num_d;
            issued_q    <= issued_d;
            pend_q      <= pend_d;
            resv_q      <= resv_d;
            cnt_q       <= cnt_d;
            beats_out_q <= beats_out_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (beat_wr) begin
            mem_q[wr_ptr_q] <= ddr_rd_data;
        end
    end

endmodule

// File: tb/tb_ddr3_sniffer_reader.sv
// Bench for ddr3_sniffer_reader: a fixed-latency DDR3 responder plus a beat/address
// scoreboard; inputs change 1ns after posedge, everything is observed on negedge.
module tb_ddr3_sniffer_reader;

    localparam int          LAT  = 5;
    localparam logic [31:0] STEP = 32'd8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  base_addr = '0;
    logic [15:0]  num_bursts = '0;
    logic         busy, done, err_unexpected;
    logic [287:0] out_data;
    logic         out_valid, out_last;
    logic         out_ready = 1'b0;
    logic [31:0]  ddr_addr;
    logic         ddr_en;
    logic [2:0]   ddr_cmd;
    logic         ddr_wdf_wren;
    logic [287:0] ddr_wdf_data;
    logic [35:0]  ddr_wdf_mask;
    logic         ddr_wdf_end;
    logic [287:0] ddr_rd_data = '0;
    logic         ddr_rd_data_valid = 1'b0;
    logic         ddr_rd_data_end = 1'b0;
    logic         ddr_rdy = 1'b0;
    logic         ddr_wdf_rdy = 1'b1;

    always #5 clk = ~clk;

    ddr3_sniffer_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_bursts(num_bursts), .busy(busy), .done(done),
        .err_unexpected(err_unexpected), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready), .ddr_addr(ddr_addr),
        .ddr_en(ddr_en), .ddr_cmd(ddr_cmd), .ddr_wdf_wren(ddr_wdf_wren),
        .ddr_wdf_data(ddr_wdf_data), .ddr_wdf_mask(ddr_wdf_mask),
        .ddr_wdf_end(ddr_wdf_end), .ddr_rd_data(ddr_rd_data),
        .ddr_rd_data_valid(ddr_rd_data_valid), .ddr_rd_data_end(ddr_rd_data_end),
        .ddr_rdy(ddr_rdy), .ddr_wdf_rdy(ddr_wdf_rdy)
    );

    typedef struct {
        int           due;
        logic [287:0] d;
        bit           e;
    } beat_t;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0, done_cyc = 0, en_cnt = 0, ov_cnt = 0, hold_viol = 0;
    int rdy_pct = 100, ordy_pct = 100;
    bit inject_spur = 1'b0;
    bit prev_en = 1'b0, prev_rdy = 1'b1;
    logic [31:0]  prev_addr = '0;
    logic [31:0]  cmd_log[$];
    logic [287:0] gen_log[$];
    logic [287:0] out_log[$];
    bit           last_log[$];
    int           hs_cyc[$];
    int           rx_cyc[$];
    beat_t        resp_q[$];

    function automatic logic [287:0] rnd_beat();
        logic [287:0] r;
        for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Observer: logs commands, beats and handshakes; the responder schedules data per accept.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (prev_en && !prev_rdy && !(ddr_en && ddr_addr == prev_addr)) hold_viol++;
        prev_en   = ddr_en;
        prev_rdy  = ddr_rdy;
        prev_addr = ddr_addr;
        if (ddr_en) en_cnt++;
        if (ddr_en && ddr_rdy) begin
            cmd_log.push_back(ddr_addr);
            for (int b = 0; b < 2; b++) begin
                beat_t x;
                x.due = cyc + LAT;
                x.d   = rnd_beat();
                x.e   = (b == 1);
                resp_q.push_back(x);
                gen_log.push_back(x.d);
            end
        end
        if (out_valid) ov_cnt++;
        if (out_valid && out_ready) begin
            out_log.push_back(out_data);
            last_log.push_back(out_last);
            hs_cyc.push_back(cyc);
        end
        if (ddr_rd_data_valid) rx_cyc.push_back(cyc);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        ddr_rdy   = ($urandom_range(99) < rdy_pct);
        out_ready = ($urandom_range(99) < ordy_pct);
        if (inject_spur) begin
            ddr_rd_data_valid = 1'b1;
            ddr_rd_data       = rnd_beat();
            ddr_rd_data_end   = 1'b0;
            inject_spur       = 1'b0;
        end else if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
            beat_t x;
            x = resp_q.pop_front();
            ddr_rd_data_valid = 1'b1;
            ddr_rd_data       = x.d;
            ddr_rd_data_end   = x.e;
        end else begin
            ddr_rd_data_valid = 1'b0;
            ddr_rd_data_end   = 1'b0;
        end
    end

    task automatic start_run(input logic [31:0] base, input logic [15:0] n);
        int t = 0;
        while (resp_q.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        cmd_log.delete(); gen_log.delete(); out_log.delete();
        last_log.delete(); hs_cyc.delete(); rx_cyc.delete();
        done_cnt = 0;
        en_cnt   = 0;
        @(posedge clk);
        #1;
        start      = 1'b1;
        base_addr  = base;
        num_bursts = n;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic finish_run(input string name, input logic [31:0] base,
                              input int n, input int max_cyc);
        int t = 0;
        logic [31:0] ea;
        while (done_cnt == 0 && t < max_cyc) begin
            @(negedge clk);
            t++;
        end
        tests++;
        if (done_cnt == 0) begin
            fails++;
            $display("FAIL %s timeout: no done after %0d cycles", name, max_cyc);
            return;
        end
        repeat (3) @(negedge clk);
        tests++;
        if (cmd_log.size() !== n) begin
            fails++;
            $display("FAIL %s cmd_count got %0d want %0d", name, cmd_log.size(), n);
        end
        for (int i = 0; i < cmd_log.size() && i < n; i++) begin
            ea = base + STEP * 32'(i);
            tests++;
            if (cmd_log[i] !== ea) begin
                fails++;
                $display("FAIL %s addr[%0d] got %h want %h", name, i, cmd_log[i], ea);
            end
        end
        tests++;
        if (out_log.size() !== 2 * n) begin
            fails++;
            $display("FAIL %s beat_count got %0d want %0d", name, out_log.size(), 2 * n);
        end
        for (int i = 0; i < out_log.size() && i < gen_log.size(); i++) begin
            tests++;
            if (out_log[i] !== gen_log[i]) begin
                fails++;
                $display("FAIL %s beat[%0d] data got %h want %h", name, i,
                         out_log[i][63:0], gen_log[i][63:0]);
            end
            tests++;
            if (last_log[i] !== (i == 2 * n - 1)) begin
                fails++;
                $display("FAIL %s beat[%0d] out_last got %0d want %0d", name, i,
                         last_log[i], (i == 2 * n - 1));
            end
        end
        tests++;
        if (done_cnt !== 1) begin
            fails++;
            $display("FAIL %s done_pulses got %0d want 1", name, done_cnt);
        end
        if (hs_cyc.size() > 0) begin
            tests++;
            if (done_cyc !== hs_cyc[hs_cyc.size() - 1] + 1) begin
                fails++;
                $display("FAIL %s done_timing got cycle %0d want %0d", name, done_cyc,
                         hs_cyc[hs_cyc.size() - 1] + 1);
            end
        end
        tests++;
        if (busy !== 1'b0 || err_unexpected !== 1'b0) begin
            fails++;
            $display("FAIL %s idle_flags busy=%b err=%b want 0 0", name, busy, err_unexpected);
        end
        tests++;
        if (hold_viol !== 0) begin
            fails++;
            $display("FAIL %s cmd_hold violations got %0d want 0", name, hold_viol);
        end
    endtask

    task automatic check_reset_values(input string name);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || ddr_en !== 1'b0 || out_valid !== 1'b0 ||
            out_last !== 1'b0 || err_unexpected !== 1'b0) begin
            fails++;
            $display("FAIL %s flags busy=%b done=%b en=%b ov=%b last=%b err=%b want all 0",
                     name, busy, done, ddr_en, out_valid, out_last, err_unexpected);
        end
        tests++;
        if (ddr_addr !== 32'h0 || out_data !== 288'h0 || ddr_cmd !== 3'b001 ||
            ddr_wdf_wren !== 1'b0 || ddr_wdf_mask !== {36{1'b1}}) begin
            fails++;
            $display("FAIL %s values addr=%h data0=%h cmd=%b wren=%b mask=%h", name,
                     ddr_addr, out_data[31:0], ddr_cmd, ddr_wdf_wren, ddr_wdf_mask);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        rdy_pct  = 100;
        ordy_pct = 100;
        start_run(32'h100, 16'd3);
        @(negedge clk);
        tests++;
        if (ddr_en !== 1'b1 || ddr_addr !== 32'h100 || busy !== 1'b1) begin
            fails++;
            $display("FAIL basic first_cmd en=%b addr=%h busy=%b want 1 100 1",
                     ddr_en, ddr_addr, busy);
        end
        finish_run("basic", 32'h100, 3, 500);
        if (rx_cyc.size() > 0 && hs_cyc.size() > 0) begin
            tests++;
            if (hs_cyc[0] !== rx_cyc[0] + 1) begin
                fails++;
                $display("FAIL basic read_latency out at %0d want %0d", hs_cyc[0], rx_cyc[0] + 1);
            end
        end
    endtask

    task automatic test_credit();
        logic [31:0] b = $urandom & 32'hFFFF_FFF8;
        @(negedge clk);
        rdy_pct  = 100;
        ordy_pct = 0;
        start_run(b, 16'd10);
        repeat (60) @(negedge clk);
        tests++;
        if (cmd_log.size() !== 4 || en_cnt !== 4 || ddr_en !== 1'b0) begin
            fails++;
            $display("FAIL credit cmds=%0d en_cycles=%0d en=%b want 4 4 0",
                     cmd_log.size(), en_cnt, ddr_en);
        end
        tests++;
        if (out_log.size() !== 0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL credit out handshakes=%0d valid=%b want 0 1", out_log.size(), out_valid);
        end
        ordy_pct = 100;
        finish_run("credit", b, 10, 1000);
    endtask

    task automatic test_stall();
        logic [31:0] b = $urandom & 32'hFFFF_FFF8;
        int t = 0;
        @(negedge clk);
        rdy_pct  = 100;
        ordy_pct = 100;
        start_run(b, 16'd6);
        while (cmd_log.size() < 2 && t < 50) begin
            @(negedge clk);
            t++;
        end
        rdy_pct = 0;
        repeat (50) @(negedge clk);
        tests++;
        if (ddr_en !== 1'b1 || ddr_addr !== b + 32'd16 || cmd_log.size() !== 2) begin
            fails++;
            $display("FAIL stall hold en=%b addr=%h cmds=%0d want 1 %h 2",
                     ddr_en, ddr_addr, cmd_log.size(), b + 32'd16);
        end
        rdy_pct = 100;
        finish_run("stall", b, 6, 1000);
    endtask

    task automatic test_spurious();
        int ov0;
        logic [31:0] b = $urandom & 32'hFFFF_FFF8;
        repeat (3) @(negedge clk);
        ov0 = ov_cnt;
        inject_spur = 1'b1;
        repeat (4) @(negedge clk);
        tests++;
        if (err_unexpected !== 1'b1 || ov_cnt !== ov0) begin
            fails++;
            $display("FAIL spurious err=%b out_valid_cycles=%0d want 1 0",
                     err_unexpected, ov_cnt - ov0);
        end
        start_run(b, 16'd1);
        @(negedge clk);
        tests++;
        if (err_unexpected !== 1'b0) begin
            fails++;
            $display("FAIL spurious_clear err got %b want 0", err_unexpected);
        end
        finish_run("spurious_run", b, 1, 500);
    endtask

    task automatic test_zero();
        start_run(32'h1234_5678, 16'd0);
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL zero done=%b busy=%b want 1 0", done, busy);
        end
        repeat (5) @(negedge clk);
        tests++;
        if (done_cnt !== 1 || en_cnt !== 0) begin
            fails++;
            $display("FAIL zero pulses=%0d en_cycles=%0d want 1 0", done_cnt, en_cnt);
        end
    endtask

    task automatic test_wrap();
        start_run(32'hFFFF_FFF8, 16'd2);
        finish_run("wrap", 32'hFFFF_FFF8, 2, 500);
        tests++;
        if (cmd_log.size() < 2 || cmd_log[1] !== 32'h0) begin
            fails++;
            $display("FAIL wrap second_addr got %h want 00000000",
                     (cmd_log.size() > 1) ? cmd_log[1] : 32'hxxxx_xxxx);
        end
    endtask

    task automatic test_reset_mid_run();
        int t = 0;
        int ov0;
        logic [31:0] b = $urandom & 32'hFFFF_FFF8;
        rdy_pct  = 100;
        ordy_pct = 100;
        start_run(b, 16'd1);
        while (cmd_log.size() < 1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #3;
        ov0   = ov_cnt;
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_drain");
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        t = 0;
        while (resp_q.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        tests++;
        if (err_unexpected !== 1'b1 || ov_cnt !== ov0) begin
            fails++;
            $display("FAIL reset_late_beats err=%b out_valid_cycles=%0d want 1 0",
                     err_unexpected, ov_cnt - ov0);
        end
        start_run(b + 32'h40, 16'd3);
        finish_run("after_reset", b + 32'h40, 3, 500);
    endtask

    task automatic test_random();
        logic [31:0] b;
        int n;
        for (int it = 0; it < 6; it++) begin
            b = $urandom;
            n = $urandom_range(12, 1);
            @(negedge clk);
            rdy_pct  = $urandom_range(100, 40);
            ordy_pct = $urandom_range(100, 30);
            start_run(b, 16'(n));
            finish_run("random", b, n, 3000);
        end
        rdy_pct  = 100;
        ordy_pct = 100;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_credit();
        test_stall();
        test_spurious();
        test_zero();
        test_wrap();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ddr3_sniffer_reader.md
# ddr3_sniffer_reader

Read-only initiator for the low-priority sniffer port of the DDR3 arbiter. It issues a host-requested run of READ bursts to consecutive addresses and captures the two-beat read responses into an internal FIFO. It streams the captured beats out on a valid/ready interface toward the OPB register bank. Outstanding bursts are credit-limited, so read data, which cannot be back-pressured, never overflows the FIFO.

## Interface
Parameters:
- MAX_OUTSTANDING, 4: maximum bursts in flight. FIFO depth is 2*MAX_OUTSTANDING beats.
- ADDR_STEP, 8: address increment per burst.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  one-cycle request pulse. Ignored while busy=1.
- base_addr  in  32  first burst address, sampled on start.
- num_bursts  in  16  burst count, sampled on start. 0 means no-op.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- err_unexpected  out  1  sticky flag. Set when read data arrives with no beats pending. Cleared by an accepted start.
- out_data  out  288  captured read beat.
- out_valid  out  1  out_data is valid.
- out_last  out  1  marks the final beat of the whole run.
- out_ready  in  1  downstream accepts the beat.
- ddr_addr  out  32  command address.
- ddr_en  out  1  command valid.
- ddr_cmd  out  3  constant 3'b001 (READ).
- ddr_wdf_wren  out  1  tied 0.
- ddr_wdf_data  out  288  tied 0.
- ddr_wdf_mask  out  36  tied all-ones.
- ddr_wdf_end  out  1  tied 0.
- ddr_rd_data  in  288  read data.
- ddr_rd_data_valid  in  1  read beat strobe.
- ddr_rd_data_end  in  1  second beat of a burst.
- ddr_rdy  in  1  command accepted when ddr_en&ddr_rdy at a clk edge.
- ddr_wdf_rdy  in  1  unused.

## Operation
- Reset values:
  - busy, done, ddr_en, out_valid, out_last, err_unexpected: 0.
  - ddr_addr, out_data: 0.
  - ddr_cmd = 3'b001.
  - The FIFO and all counters are cleared.
- States:
  - IDLE → ISSUE on an accepted start with num_bursts≠0.
  - An accepted start with num_bursts=0 skips ISSUE: it produces a done pulse the next cycle and stays in IDLE.
  - ISSUE → DRAIN when the last command is accepted.
  - DRAIN → IDLE once pending_beats=0 and the FIFO is empty. done pulses on that transition.
- Counters:
  - issued (16 bit).
  - pending_beats, which rises by 2 per accepted command and falls by 1 per received beat.
  - reserved, which rises by 2 per accepted command and falls by 1 per out handshake.
  - beats_out (17 bit), used to flag out_last when it equals 2*num_bursts−1.
- Issue rule: ddr_en=1 in ISSUE only while reserved ≤ 2*MAX_OUTSTANDING−2. This guarantees FIFO space for every beat in flight.
- Command hold: ddr_en and ddr_addr are held stable until ddr_rdy. The arbiter may drive ddr_rdy=0 indefinitely while the high-priority port owns DDR3.
- Address: first command uses base_addr. Each accept adds ADDR_STEP, modulo 2^32 (wrap allowed, no error).
- Read capture: a beat is written to the FIFO when ddr_rd_data_valid=1 and pending_beats>0. When pending_beats=0, the beat is dropped and err_unexpected is set. The arbiter forwards read data to this port while idle, so such beats can arrive.
- ddr_rd_data_end is not used for counting; beats are counted by valid only.
- Simultaneous events:
  - A command accept and a beat receive in the same cycle change pending_beats by +1 net.
  - Reserved is updated the same way when an accept and an out handshake coincide.
  - FIFO write and read in the same cycle are both performed, including when the FIFO is full-with-read or empty-with-write (write-through takes 1 cycle).
- Reset mid-run: everything clears asynchronously and ddr_en drops immediately. Beats arriving after reset are flagged as unexpected.

## Timing
- Start to first ddr_en: 1 cycle.
- Back-to-back commands: after an accept, the next command may be presented in the following cycle, credit permitting. Sustained rate is 1 command per cycle.
- Beat received at edge N appears on out_valid after edge N, i.e. 1 cycle latency.
- out_valid stays asserted with stable data until out_ready.
- done is asserted in the cycle after the final out handshake. busy deasserts in that same cycle.

## Test plan
- Basic run: base_addr=0x100, num_bursts=3, with ddr_rdy=1, out_ready=1, and responder latency 5.
  - Expect commands at 0x100, 0x108, 0x110.
  - Expect 6 beats out in order, with out_last only on beat 6.
  - Expect one done pulse.
- Credit limit: MAX_OUTSTANDING=4, num_bursts=10, out_ready=0.
  - Exactly 4 commands are issued, then ddr_en=1 is never raised again.
  - Raising out_ready lets the run complete with 20 beats and no loss.
- Arbiter stall: ddr_rdy=0 for 50 cycles mid-run.
  - ddr_en and ddr_addr are held constant through the stall.
  - The run completes with the correct addresses.
- Spurious data: pulse ddr_rd_data_valid while idle.
  - No out_valid, and err_unexpected=1.
  - A following start clears it.
- Edge cases:
  - num_bursts=0 gives a done pulse 1 cycle after start with no ddr_en.
  - base_addr=0xFFFFFFF8 with num_bursts=2 wraps the second command to 0x00000000.
- Reset in DRAIN with 2 beats pending: all outputs return to their reset values immediately, and the block accepts a new start afterwards.
